// File: rtl/alu_pkg.sv
// Shared ALU encodings: ALUOp values, R-type funct codes, ALU select enum.
// Imported by the ALU control decoder and by the ALU itself.
package alu_pkg;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // SEL_NOP makes the ALU pass operand A through unchanged
    typedef enum logic [2:0] {
        SEL_AND = 3'b000,
        SEL_OR  = 3'b001,
        SEL_ADD = 3'b010,
        SEL_NOP = 3'b011,
        SEL_SUB = 3'b110,
        SEL_SLT = 3'b111
    } alu_sel_e;

    // Decoder response: select code plus unsupported-encoding flag
    typedef struct packed {
        alu_sel_e sel;
        logic     illegal;
    } alu_ctl_t;

endpackage

// File: rtl/alu_funct_decode.sv
// R-type funct -> {select, illegal} lookup. Full 6-bit compare, so any
// funct outside the supported set maps to SEL_NOP and flags illegal.
module alu_funct_decode
    import alu_pkg::*;
(
    input  logic [5:0] funct,
    output alu_ctl_t   ctl
);

    // Combinational funct lookup; default arm keeps outputs X-free
    always_comb begin
        ctl = '{sel: SEL_NOP, illegal: 1'b1};
        case (funct)
            FUNCT_ADD: ctl = '{sel: SEL_ADD, illegal: 1'b0};
            FUNCT_SUB: ctl = '{sel: SEL_SUB, illegal: 1'b0};
            FUNCT_AND: ctl = '{sel: SEL_AND, illegal: 1'b0};
            FUNCT_OR:  ctl = '{sel: SEL_OR,  illegal: 1'b0};
            FUNCT_SLT: ctl = '{sel: SEL_SLT, illegal: 1'b0};
            default:   ctl = '{sel: SEL_NOP, illegal: 1'b1};
        endcase
    end

endmodule

// File: rtl/alu_control.sv
// EX-stage ALU control: ALUOp/funct -> ALU select code, plus a sticky
// debug flag recording any unsupported encoding since reset.
// Build option: ALU_CONTROL_SELECT_REG_EN registers select/illegal
// (1-cycle latency, reset to add/legal); otherwise they are combinational.
module alu_control
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] select,
    output logic       illegal,
    output logic       illegal_seen
);

    alu_ctl_t rtype_ctl;
    alu_ctl_t dec_ctl;

    alu_funct_decode u_funct_decode (
        .funct (funct),
        .ctl   (rtype_ctl)
    );

    // ALUOp mux: memory/branch ops ignore funct, reserved op is a NOP
    always_comb begin
        dec_ctl = '{sel: SEL_NOP, illegal: 1'b1};
        case (alu_op)
            ALUOP_MEM:   dec_ctl = '{sel: SEL_ADD, illegal: 1'b0};
            ALUOP_BEQ:   dec_ctl = '{sel: SEL_SUB, illegal: 1'b0};
            ALUOP_RTYPE: dec_ctl = rtype_ctl;
            ALUOP_RSVD:  dec_ctl = '{sel: SEL_NOP, illegal: 1'b1};
            default:     dec_ctl = '{sel: SEL_NOP, illegal: 1'b1};
        endcase
    end

`ifdef ALU_CONTROL_SELECT_REG_EN
    alu_ctl_t ctl_q;

    // Output register, loaded every edge; resets to a legal add
    always_ff @(posedge clk) begin
        if (rst) ctl_q <= '{sel: SEL_ADD, illegal: 1'b0};
        else     ctl_q <= dec_ctl;
    end

    assign select  = ctl_q.sel;
    assign illegal = ctl_q.illegal;
`else
    assign select  = dec_ctl.sel;
    assign illegal = dec_ctl.illegal;
`endif

    // Sticky unsupported-encoding flag; reset wins over a same-edge set
    always_ff @(posedge clk) begin
        if (rst)          illegal_seen <= 1'b0;
        else if (illegal) illegal_seen <= 1'b1;
    end

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: directed steps, a full 256-pair
// sweep and a randomized run, against a table-style reference model.
module tb_alu_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] alu_op = 2'd0;
    logic [5:0] funct = 6'd0;
    logic [2:0] select;
    logic       illegal;
    logic       illegal_seen;

    int ncmp  = 0;
    int nfail = 0;

    alu_control dut (
        .clk          (clk),
        .rst          (rst),
        .alu_op       (alu_op),
        .funct        (funct),
        .select       (select),
        .illegal      (illegal),
        .illegal_seen (illegal_seen)
    );

    always #5 clk = ~clk;

    // Reference: the supported instruction table written as plain numbers
    function automatic logic [2:0] ref_sel(input logic [1:0] op, input logic [5:0] f);
        int fi;
        fi = int'(f);
        if (op == 2'd0) return 3'd2;
        if (op == 2'd1) return 3'd6;
        if (op == 2'd3) return 3'd3;
        if (fi == 32) return 3'd2;
        if (fi == 34) return 3'd6;
        if (fi == 36) return 3'd0;
        if (fi == 37) return 3'd1;
        if (fi == 42) return 3'd7;
        return 3'd3;
    endfunction

    function automatic logic ref_ill(input logic [1:0] op, input logic [5:0] f);
        int fi;
        fi = int'(f);
        if (op == 2'd3) return 1'b1;
        if (op != 2'd2) return 1'b0;
        return !(fi == 32 || fi == 34 || fi == 36 || fi == 37 || fi == 42);
    endfunction

    // Expected registered outputs (used by the registered build) and sticky flag
    logic [2:0] exp_sel_q  = 3'd2;
    logic       exp_ill_q  = 1'b0;
    logic       model_seen = 1'b0;

    always @(posedge clk) begin
        exp_sel_q <= rst ? 3'd2 : ref_sel(alu_op, funct);
        exp_ill_q <= rst ? 1'b0 : ref_ill(alu_op, funct);
`ifdef ALU_CONTROL_SELECT_REG_EN
        model_seen <= rst ? 1'b0 : (model_seen | exp_ill_q);
`else
        model_seen <= rst ? 1'b0 : (model_seen | ref_ill(alu_op, funct));
`endif
    end

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0d expected %0d (op=%0b funct=%06b)", tag, got, exp, alu_op, funct);
        end
    endtask

    // One cycle: check state at negedge, drive new inputs, check comb outputs
    task automatic step(input logic [1:0] op, input logic [5:0] f, input logic r);
        @(negedge clk);
        chk("illegal_seen", {2'b00, illegal_seen}, {2'b00, model_seen});
`ifdef ALU_CONTROL_SELECT_REG_EN
        chk("select_q", select, exp_sel_q);
        chk("illegal_q", {2'b00, illegal}, {2'b00, exp_ill_q});
`endif
        alu_op = op;
        funct  = f;
        rst    = r;
        #1;
`ifndef ALU_CONTROL_SELECT_REG_EN
        chk("select", select, ref_sel(op, f));
        chk("illegal", {2'b00, illegal}, {2'b00, ref_ill(op, f)});
`endif
    endtask

    initial begin
        // reset for two edges
        repeat (2) @(negedge clk);
        chk("reset_seen", {2'b00, illegal_seen}, 3'd0);
`ifdef ALU_CONTROL_SELECT_REG_EN
        chk("reset_select", select, 3'd2);
        chk("reset_illegal", {2'b00, illegal}, 3'd0);
`endif
        // memory and branch ops
        step(2'b00, 6'b100000, 1'b0);
        step(2'b01, 6'b100000, 1'b0);
        // supported R-type functs
        step(2'b10, 6'b100000, 1'b0);
        step(2'b10, 6'b100010, 1'b0);
        step(2'b10, 6'b100100, 1'b0);
        step(2'b10, 6'b100101, 1'b0);
        step(2'b10, 6'b101010, 1'b0);
        // reserved op sets the sticky flag, which survives legal inputs
        step(2'b11, 6'b101100, 1'b0);
        step(2'b00, 6'b100000, 1'b0);
        step(2'b10, 6'b100000, 1'b0);
        // unsupported funct, then reset on an edge with illegal still high
        step(2'b10, 6'b000000, 1'b0);
        step(2'b10, 6'b000000, 1'b1);
        step(2'b10, 6'b000000, 1'b1);
        step(2'b10, 6'b000000, 1'b0);
        // reset then a registered-latency probe: and after add
        step(2'b00, 6'b000000, 1'b1);
        step(2'b10, 6'b100100, 1'b0);
        step(2'b10, 6'b100100, 1'b0);
        // exhaustive sweep of all 256 pairs
        for (int i = 0; i < 256; i++) begin
            logic [7:0] pair;
            pair = 8'(i);
            step(pair[7:6], pair[5:0], 1'b0);
        end
        // randomized run, biased toward R-type with occasional reset
        for (int i = 0; i < 400; i++) begin
            logic [1:0] op;
            logic [5:0] f;
            logic       r;
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) op = 2'b10;
            f = 6'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 4))
                    0: f = 6'b100000;
                    1: f = 6'b100010;
                    2: f = 6'b100100;
                    3: f = 6'b100101;
                    default: f = 6'b101010;
                endcase
            end
            r = ($urandom_range(0, 15) == 0);
            step(op, f, r);
        end
        step(2'b00, 6'b000000, 1'b0);
        step(2'b00, 6'b000000, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/alu_control.md
# alu_control

EX-stage ALU control decoder of the 5-stage MIPS pipeline. It maps the 2-bit ALUOp from the ID/EX pipeline register and the 6-bit R-type funct field to the 3-bit ALU select code consumed by the ALU. The decode is combinational. A small clocked block records unsupported encodings for debug.

## Interface
- No parameters; all widths fixed by the MIPS encoding.
- One clock; reset is synchronous and active-high.
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- alu_op  input  2  ALUOp from the main control unit.
- funct  input  6  instruction bits [5:0].
- select  output  3  ALU operation code.
- illegal  output  1  current alu_op/funct pair is unsupported.
- illegal_seen  output  1  sticky flag: an unsupported pair was sampled since reset.

## Operation
- alu_op 00 (lw/sw/addi): select = 010 (add); funct ignored.
- alu_op 01 (beq): select = 110 (subtract); funct ignored.
- alu_op 10 (R-type), full 6-bit funct compare:
  - 100000 add -> 010
  - 100010 sub -> 110
  - 100100 and -> 000
  - 100101 or -> 001
  - 101010 slt -> 111
  - any other funct -> 011 with illegal = 1
- alu_op 11 is reserved: select = 011 and illegal = 1 for every funct (including 101100).
- Select code 011 is the "no operation" code; the ALU passes operand A through for it.
- illegal = 0 for every supported pair.
- No X may appear on outputs for any 2-valued input combination.

## Timing
- Default build: select and illegal are purely combinational, with zero-cycle latency. An input change is reflected in the same delta cycle.
- illegal_seen:
  - Is cleared to 0 on a rising clk edge with rst = 1.
  - Is otherwise set to 1 on any rising edge where illegal = 1.
  - Once set, holds until the next reset.
  - Reset has priority when rst = 1 and illegal = 1 on the same edge.
- Reset does not affect combinational select or illegal.

## Configuration
- ALU_CONTROL_SELECT_REG_EN defined:
  - select and illegal come from flops loaded every rising edge, giving a 1-cycle latency.
  - Reset values: select = 010, illegal = 0.
  - illegal_seen is set from the registered illegal.
- Not defined: combinational outputs as described in Operation.

## Structure
- The shared package alu_pkg holds:
  - ALUOp constants: ALUOP_MEM = 00, ALUOP_BEQ = 01, ALUOP_RTYPE = 10, ALUOP_RSVD = 11.
  - funct constants: FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT.
  - The 3-bit select enum: SEL_AND = 000, SEL_OR = 001, SEL_ADD = 010, SEL_NOP = 011, SEL_SUB = 110, SEL_SLT = 111.
  - The same package is imported by the ALU.
- One natural sub-module, alu_funct_decode: a combinational funct -> {select, illegal} lookup used for the R-type branch.
- Top level holds the alu_op mux, the optional output register and the sticky flag.

## Test plan
- alu_op = 00 with funct = 100000, then alu_op = 01 with funct = 100000 -> select = 010 then 110; illegal = 0 both.
- alu_op = 10, funct stepped 100000, 100010, 100100, 100101, 101010 -> select 010, 110, 000, 001, 111; illegal = 0 throughout.
- alu_op = 11, funct = 101100 -> select = 011, illegal = 1; illegal_seen = 1 after the next clk edge and stays 1 after inputs return legal.
- alu_op = 10, funct = 000000 -> select = 011, illegal = 1; then rst = 1 for one edge -> illegal_seen = 0. The same edge with illegal still asserted also leaves illegal_seen = 0.
- With ALU_CONTROL_SELECT_REG_EN:
  - Apply rst, then alu_op = 10, funct = 100100 -> select = 010 until the next edge, then 000.
  - Sweep all 256 input pairs -> each output equals the default-build value delayed by exactly one edge.
